alu_cmd_sequencer: RTL and testbench

Command-side controller for the 8-bit combinational ALU. It accepts operation commands over a valid/ready handshake, drives the ALU operand and opcode inputs, and waits a programmable settle time. It then captures alu_out, alu_zero and alu_carry, and returns them on a valid/ready response channel. It also keeps an 8-bit accumulator for chained operations and saturating operation and error counters.

---
 rtl/alu_cmd_sequencer.sv | 103 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command sequencer in front of an 8-bit combinational ALU
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_opcode, cmd_a, cmd_b, cmd_use_acc carry the command
//   acc_clear                     zeroes the accumulator on the next edge, wins over a capture
//   alu_in_a/alu_in_b/alu_opcode  operands and opcode to the ALU (opcode is 0 outside ISSUE)
//   alu_out/alu_zero/alu_carry    ALU result, captured after SETTLE cycles
//   rsp_valid/rsp_ready           response handshake; rsp_data, rsp_zero, rsp_carry, rsp_illegal carry the result
//   acc, op_count, err_count      accumulator and saturating legal-op and illegal-op counters
module alu_cmd_sequencer #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_use_acc,
    input  logic             acc_clear,
    output logic [7:0]       alu_in_a,
    output logic [7:0]       alu_in_b,
    output logic [3:0]       alu_opcode,
    input  logic [7:0]       alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_illegal,
    output logic [7:0]       acc,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, next;
    logic [3:0] cnt, op_q;
    logic accept, capture, legal;
    // gating with rst_n keeps cmd_ready low for the whole reset window
    assign cmd_ready  = rst_n && state == IDLE;
    assign accept     = cmd_valid && cmd_ready;
    assign capture    = state == ISSUE && cnt == 4'd0;
    assign legal      = op_q != 4'd0 && op_q <= 4'd11;
    assign rsp_valid  = state == RESP;
    assign alu_opcode = state == ISSUE ? op_q : 4'd0;
    always_comb begin
        next = state;
        if (accept)
            next = ISSUE;
        else if (capture)
            next = RESP;
        else if (state == RESP && rsp_ready)
            next = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 4'd0;
            op_q        <= 4'd0;
            alu_in_a    <= 8'd0;
            alu_in_b    <= 8'd0;
            rsp_data    <= 8'd0;
            rsp_zero    <= 1'b0;
            rsp_carry   <= 1'b0;
            rsp_illegal <= 1'b0;
            acc         <= 8'd0;
            op_count    <= '0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                alu_in_a <= cmd_use_acc ? acc : cmd_a;
                alu_in_b <= cmd_b;
                op_q     <= cmd_opcode;
                cnt      <= 4'(SETTLE - 1);
            end else if (state == ISSUE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_data    <= legal ? alu_out : 8'd0;
                rsp_zero    <= legal ? alu_zero : 1'b1;
                rsp_carry   <= legal && alu_carry;
                rsp_illegal <= !legal;
                if (legal && op_count != '1)
                    op_count <= op_count + 1'b1;
                if (!legal && err_count != '1)
                    err_count <= err_count + 1'b1;
            end
            if (acc_clear)
                acc <= 8'd0;
            else if (capture && legal)
                acc <= alu_out;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and randomized checks of alu_cmd_sequencer against a behavioural model
module tb_alu_cmd_sequencer;
    localparam int S = 3;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst_n, cmd_valid, cmd_ready, cmd_use_acc, acc_clear;
    logic [3:0] cmd_opcode, alu_opcode;
    logic [7:0] cmd_a, cmd_b, alu_in_a, alu_in_b, alu_out, rsp_data, acc;
    logic alu_zero, alu_carry, rsp_valid, rsp_ready, rsp_zero, rsp_carry, rsp_illegal;
    logic [W-1:0] op_count, err_count;
    int tests = 0;
    int fails = 0;
    logic [7:0] acc_m, p_ea, p_b;
    logic [3:0] p_op;
    int opc_m, errc_m;
    bit clr_hit;

    alu_cmd_sequencer #(.SETTLE(S), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .acc_clear(acc_clear), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_illegal(rsp_illegal), .acc(acc), .op_count(op_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // stand-in ALU: {carry, result}
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1:    return {1'b0, a} + {1'b0, b};
            4'd2:    return {1'b0, a} - {1'b0, b};
            4'd3:    return {1'b0, a & b};
            4'd4:    return {1'b0, a | b};
            4'd5:    return {1'b0, a ^ b};
            4'd6:    return {1'b0, ~a};
            4'd7:    return {a, 1'b0};
            4'd8:    return {a[0], 1'b0, a[7:1]};
            4'd9:    return {1'b0, a} + 9'd1;
            4'd10:   return {1'b0, a} - 9'd1;
            4'd11:   return {1'b0, ~a + 8'd1};
            default: return 9'd0;
        endcase
    endfunction

    assign {alu_carry, alu_out} = alu_f(alu_opcode, alu_in_a, alu_in_b);
    assign alu_zero = alu_out == 8'd0;

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", t, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input bit ua);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
        p_op = op; p_b = b; p_ea = ua ? acc_m : a;
        tick();
        cmd_valid = 0;
        chk("issue_in_a", alu_in_a, p_ea);
        chk("issue_in_b", alu_in_b, p_b);
        chk("issue_opcode", alu_opcode, p_op);
        chk("issue_ready", cmd_ready, 0);
    endtask

    task automatic finish(input int el, input int hold, input bit poke);
        int lat = 0;
        logic [8:0] r;
        logic [7:0] ed;
        bit lg;
        while (!rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("latency", lat, el);
        lg = p_op inside {[4'd1:4'd11]};
        r = alu_f(p_op, p_ea, p_b);
        ed = lg ? r[7:0] : 8'd0;
        if (lg) begin
            opc_m++;
            acc_m = r[7:0];
        end else
            errc_m++;
        if (clr_hit)
            acc_m = 8'd0;
        clr_hit = 0;
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, ed);
            chk("rsp_zero", rsp_zero, lg ? (ed == 8'd0) : 1'b1);
            chk("rsp_carry", rsp_carry, lg & r[8]);
            chk("rsp_illegal", rsp_illegal, !lg);
            chk("resp_ready_low", cmd_ready, 0);
            chk("resp_opcode", alu_opcode, 0);
            if (i < hold) begin
                if (poke) begin
                    cmd_valid = 1; cmd_a = ~p_ea; cmd_use_acc = 0;
                end
                tick();
            end
        end
        chk("acc", acc, acc_m);
        chk("op_count", op_count, opc_m);
        chk("err_count", err_count, errc_m);
        cmd_valid = 0;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("back_idle_ready", cmd_ready, 1);
        chk("back_idle_valid", rsp_valid, 0);
        chk("held_in_a", alu_in_a, p_ea);
    endtask

    initial begin
        int seen, last, c;
        rst_n = 0; cmd_valid = 0; cmd_opcode = 0; cmd_a = 0; cmd_b = 0; cmd_use_acc = 0;
        acc_clear = 0; rsp_ready = 0; acc_m = 0; opc_m = 0; errc_m = 0; clr_hit = 0;
        #12;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_opc", op_count, 0);
        chk("rst_errc", err_count, 0);
        chk("rst_alu_op", alu_opcode, 0);
        chk("rst_in_a", alu_in_a, 0);
        chk("rst_data", rsp_data, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("post_rst_ready", cmd_ready, 1);
        start(4'd1, 8'hF0, 8'h20, 0);
        finish(S, 0, 0);
        start(4'd1, 8'hFF, 8'h00, 0);
        finish(S, 0, 0);
        start(4'd9, 8'h55, 8'h00, 1);
        finish(S, 0, 0);
        start(4'd2, 8'h10, 8'h20, 0);
        finish(S, 5, 1);
        start(4'hC, 8'h12, 8'h34, 0);
        finish(S, 0, 0);
        cmd_valid = 1; cmd_opcode = 4'd5; cmd_a = 8'h3C; cmd_b = 8'hA5; cmd_use_acc = 0; rsp_ready = 1;
        seen = 0; last = -1; c = 0;
        while (seen < 4 && c < 200) begin
            tick();
            c++;
            if (cmd_ready || rsp_valid)
                chk("b2b_opcode_idle", alu_opcode, 0);
            else
                chk("b2b_opcode_issue", alu_opcode, 5);
            if (rsp_valid) begin
                seen++;
                opc_m++;
                acc_m = 8'h99;
                chk("b2b_data", rsp_data, 8'h99);
                chk("b2b_opc", op_count, opc_m);
                if (last >= 0)
                    chk("b2b_period", c - last, S + 2);
                last = c;
                if (seen == 4)
                    cmd_valid = 0;
            end
        end
        chk("b2b_count", seen, 4);
        tick();
        rsp_ready = 0;
        chk("b2b_idle", cmd_ready, 1);
        for (int i = 0; i < 40; i++) begin
            start(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
            finish(S, $urandom_range(0, 3), 1'($urandom));
        end
        start(4'd4, 8'hA5, 8'h0F, 0);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_acc", acc, 0);
        chk("mid_rst_opc", op_count, 0);
        chk("mid_rst_errc", err_count, 0);
        chk("mid_rst_op", alu_opcode, 0);
        chk("mid_rst_in_a", alu_in_a, 0);
        acc_m = 0; opc_m = 0; errc_m = 0;
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("mid_rst_release", cmd_ready, 1);
        start(4'd1, 8'h40, 8'h41, 0);
        finish(S, 0, 0);
        start(4'd1, 8'h7F, 8'h01, 1);
        repeat (S - 1) tick();
        acc_clear = 1;
        clr_hit = 1;
        finish(1, 0, 0);
        acc_clear = 0;
        start(4'd1, 8'h55, 8'h01, 1);
        finish(S, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
